// File: rtl/gcd_hw_sequencer.sv
// =============================================================================
// Module   : gcd_hw_sequencer
// Brief    : Stein binary-GCD sequencer (INI/SUB/MULT/DONE). Optional build
//            macro GCD_SINGLE_STEP_EN gates SUB/MULT steps on CEN pulses.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module gcd_hw_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             board_clk,
    input  logic             Reset,
    input  logic             Start_Ack,
    input  logic             CEN,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic             q_I,
    output logic             q_Sub,
    output logic             q_Mult,
    output logic             q_Done,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] AB_GCD,
    output logic [CNT_W-1:0] i_count
);

    typedef enum logic [1:0] {
        ST_INI  = 2'd0,
        ST_SUB  = 2'd1,
        ST_MULT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One-hot flag codes, ordered {q_I, q_Sub, q_Mult, q_Done}
    localparam logic [3:0] FL_INI  = 4'b1000;
    localparam logic [3:0] FL_SUB  = 4'b0100;
    localparam logic [3:0] FL_MULT = 4'b0010;
    localparam logic [3:0] FL_DONE = 4'b0001;

    state_t     state;
    logic [3:0] flags;
    logic       advance;

`ifdef GCD_SINGLE_STEP_EN
    assign advance = CEN;
`else
    logic unused_cen;
    assign unused_cen = CEN;
    assign advance    = 1'b1;
`endif

    assign {q_I, q_Sub, q_Mult, q_Done} = flags;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state   <= ST_INI;
            flags   <= FL_INI;
            A       <= '0;
            B       <= '0;
            AB_GCD  <= '0;
            i_count <= '0;
        end else begin
            case (state)
                ST_INI: begin
                    if (Start_Ack) begin
                        A       <= Ain;
                        B       <= Bin;
                        i_count <= '0;
                        AB_GCD  <= '0;
                        state   <= ST_SUB;
                        flags   <= FL_SUB;
                    end
                end
                ST_SUB: begin
                    if (advance) begin
                        if (A == '0 || B == '0) begin
                            AB_GCD <= A | B;
                            state  <= ST_DONE;
                            flags  <= FL_DONE;
                        end else if (A == B) begin
                            AB_GCD <= A;
                            if (i_count == '0) begin
                                state <= ST_DONE;
                                flags <= FL_DONE;
                            end else begin
                                state <= ST_MULT;
                                flags <= FL_MULT;
                            end
                        end else if (A < B) begin
                            A <= B;
                            B <= A;
                        end else if (!A[0] && !B[0]) begin
                            A       <= A >> 1;
                            B       <= B >> 1;
                            i_count <= i_count + CNT_W'(1);
                        end else if (!A[0]) begin
                            A <= A >> 1;
                        end else if (!B[0]) begin
                            B <= B >> 1;
                        end else begin
                            // A > B here, so the difference cannot wrap
                            A <= A - B;
                        end
                    end
                end
                ST_MULT: begin
                    if (advance) begin
                        AB_GCD  <= AB_GCD << 1;
                        i_count <= i_count - CNT_W'(1);
                        if (i_count == CNT_W'(1)) begin
                            state <= ST_DONE;
                            flags <= FL_DONE;
                        end
                    end
                end
                default: begin
                    if (Start_Ack) begin
                        state <= ST_INI;
                        flags <= FL_INI;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/gcd_hw_sequencer.md
# gcd_hw_sequencer

Hardware sequencer for the 8-bit GCD datapath. It replaces the software state machine with a fabric FSM (INI, SUB, MULT, DONE) using the Stein binary-GCD method. It sits between the debounced button pulses (Start/Ack, single-step CEN) and the LED/SSD display muxing, and drives the same `q_*` state flags and A/B/AB_GCD/i_count display registers.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width.
- `CNT_W`, 4: `i_count` width. Must hold WIDTH-1.

Ports:
- `board_clk`  in  1  system clock. The whole block is clocked on its rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `Start_Ack`  in  1  one-clock SCEN pulse. Means Start in INI and Ack in DONE.
- `CEN`  in  1  one-clock single-step pulse.
- `Ain`  in  WIDTH  operand A. Sampled on Start.
- `Bin`  in  WIDTH  operand B. Sampled on Start.
- `q_I`, `q_Sub`, `q_Mult`, `q_Done`  out  1 each  one-hot state flags.
- `A`, `B`  out  WIDTH  working operands.
- `AB_GCD`  out  WIDTH  result.
- `i_count`  out  CNT_W  count of common factors of 2.

## Operation
- Reset values: `q_I`=1, all other flags 0; `A`=`B`=`AB_GCD`=0; `i_count`=0.
- All outputs are registered.
- An "advance" condition gates SUB and MULT (see Configuration).
- INI:
  - On `Start_Ack`: `A`<=`Ain`, `B`<=`Bin`, `i_count`<=0, `AB_GCD`<=0, go to SUB.
  - Otherwise hold.
- SUB, on advance, checks in priority order:
  1. `A`==0 or `B`==0: `AB_GCD`<=`A`|`B`, go to DONE. Zero can only occur on the first SUB cycle; 0,0 gives 0.
  2. `A`==`B`: `AB_GCD`<=`A`. If `i_count`==0 go to DONE, else go to MULT.
  3. `A`<`B`: swap `A` and `B`.
  4. Both even: halve both and `i_count`+1.
  5. Only `A` even: `A`>>=1.
  6. Only `B` even: `B`>>=1.
  7. Otherwise: `A`<=`A`-`B`. Always non-negative because step 3 runs first.
- MULT, on advance: `AB_GCD`<<=1 and `i_count`-1. When `i_count`==1 before the update, go to DONE.
  - No overflow is possible: the result is at most min(Ain,Bin).
- DONE: on `Start_Ack`, go to INI. `A`, `B`, `AB_GCD` and `i_count` hold their values.
- `Start_Ack` in SUB or MULT is ignored.
- `CEN` in INI or DONE is ignored.
- Asynchronous `Reset` in any state returns to reset values. No partial result is retained.

## Timing
- Start sampled at edge N: `q_Sub`=1 after edge N; `A`/`B` are loaded at the same edge.
- Each SUB or MULT step takes exactly one advance cycle.
- State flags change on the same edge as the datapath update. Flags are always one-hot.
- Worst-case SUB length for WIDTH=8 is at most 2*WIDTH+1 advance cycles per swap/subtract pair, and is bounded. The bench must flag more than 64 advances in SUB.
- Ack sampled at edge M in DONE: `q_I`=1 after edge M.
- A Start pulse coincident with the INI entry edge is not seen. Start is only sampled while already in INI.

## Configuration
- `GCD_SINGLE_STEP_EN`:
  - Defined: advance = `CEN`. SUB and MULT move one step per `CEN` pulse and hold otherwise.
  - Undefined: advance = 1. SUB and MULT run every clock, and the `CEN` input is unused.
- INI/DONE handshaking is identical in both builds.

## Test plan
- Build without macro, Ain=36, Bin=24, Start: the bench must observe, in order:
  - SUB (A,B) = (18,12), (9,6), (9,3), (6,3), (3,3).
  - MULT with AB_GCD=3 and i_count=2.
  - AB_GCD 6 then 12.
  - DONE with AB_GCD=12 exactly 8 cycles after the Start edge.
- Ain=5, Bin=15: swap to (15,5), then (10,5), then (5,5). DONE with AB_GCD=5 and i_count=0. No MULT state is visited.
- Ain=0, Bin=7 gives DONE with AB_GCD=7 after one SUB cycle. Ain=0, Bin=0 gives AB_GCD=0.
- Build with macro, Ain=36, Bin=24: A/B hold between `CEN` pulses, and 8 `CEN` pulses reach DONE=12. Extra `Start_Ack` pulses mid-SUB have no effect.
- Assert `Reset` during MULT: all flags and registers go to reset values immediately (asynchronously). The next Start with 8,12 yields AB_GCD=4.
- In DONE, hold several cycles with no Ack: values stay stable. Ack returns to INI with `q_I`=1 on the next cycle.
